// File: rtl/sram_controller_if.sv
// Pipeline-side port bundle of the SRAM controller: word request in, read data
// and ready back out to the memory stage.
interface sram_controller_if #(
    parameter int DATA_LEN    = 32,
    parameter int ADDRESS_LEN = 32
);
    // Handshake: the master raises MEM_R_EN or MEM_W_EN with ALU_Res/Val_Rm and
    // holds all of them steady while ready is low; the access is finished in the
    // cycle ready is high, and MEM_OUT carries the read word from that cycle on.
    logic                   MEM_R_EN;
    logic                   MEM_W_EN;
    logic [ADDRESS_LEN-1:0] ALU_Res;
    logic [DATA_LEN-1:0]    Val_Rm;
    logic [DATA_LEN-1:0]    MEM_OUT;
    logic                   ready;

    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm,
        input  MEM_OUT, ready
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm,
        output MEM_OUT, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline access into two wait-stated 16-bit transactions
// on an asynchronous SRAM, low half first; ready stays low while one is in flight.
module sram_controller #(
    parameter int DATA_LEN      = 32,
    parameter int ADDRESS_LEN   = 32,
    parameter int SRAM_ADDR_LEN = 18,
    parameter int SRAM_DATA_LEN = 16,
    parameter int BASE_ADDR     = 1024,
    parameter int WAIT_CYCLES   = 2,
    localparam int N            = WAIT_CYCLES + 1,
    localparam int CNT_W        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_controller_if.slave         bus,
    output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
    output logic                     SRAM_WE_N,
    inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
    output logic [1:0]               dbg_state,
    output logic [CNT_W-1:0]         dbg_cnt,
    output logic                     dbg_dq_oe
);
    localparam int WW = SRAM_ADDR_LEN - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state, state_d;
    logic [CNT_W-1:0]         cnt, cnt_d;
    logic                     op_wr, op_wr_d;
    logic [WW-1:0]            w_addr, w_addr_d;
    logic [DATA_LEN-1:0]      wdata, wdata_d;
    logic [SRAM_DATA_LEN-1:0] rbuf_lo;
    logic [SRAM_DATA_LEN-1:0] dq_out, dq_out_d;
    logic                     dq_oe, dq_oe_d;
    logic [SRAM_ADDR_LEN-1:0] addr_d;
    logic                     we_n_d;
    logic [DATA_LEN-1:0]      mem_out;
    logic                     req;
    logic                     phase_end;

    assign req       = bus.MEM_R_EN | bus.MEM_W_EN;
    assign phase_end = (cnt == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state logic; the request is captured on the IDLE->LO transition
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        op_wr_d  = op_wr;
        w_addr_d = w_addr;
        wdata_d  = wdata;
        case (state)
            IDLE: begin
                if (req) begin
                    state_d  = LO;
                    cnt_d    = '0;
                    op_wr_d  = bus.MEM_W_EN;
                    w_addr_d = WW'((bus.ALU_Res - ADDRESS_LEN'(BASE_ADDR)) >> 2);
                    wdata_d  = bus.Val_Rm;
                end
            end
            LO: begin
                if (phase_end) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HI: begin
                if (phase_end) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: SRAM pins are registered, so they are derived from the
    // next state and count and line up exactly with the phase they belong to.
    always_comb begin
        addr_d   = SRAM_ADDR;
        we_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        dq_out_d = dq_out;
        if (state_d == LO || state_d == HI) begin
            addr_d = {w_addr_d, (state_d == HI)};
            if (op_wr_d) begin
                dq_oe_d  = 1'b1;
                dq_out_d = (state_d == HI) ? wdata_d[DATA_LEN-1:SRAM_DATA_LEN]
                                           : wdata_d[SRAM_DATA_LEN-1:0];
                // Strobe rises on the last cycle so data and address outlive it
                we_n_d   = (cnt_d == LAST);
            end
        end
    end

    assign bus.ready = (state == DONE) || (state == IDLE && !req);

    always_ff @(posedge clk) begin
        if (!rst) begin
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            op_wr     <= 1'b0;
            w_addr    <= '0;
            wdata     <= '0;
            rbuf_lo   <= '0;
            mem_out   <= '0;
        end else begin
            SRAM_ADDR <= addr_d;
            SRAM_WE_N <= we_n_d;
            dq_oe     <= dq_oe_d;
            dq_out    <= dq_out_d;
            op_wr     <= op_wr_d;
            w_addr    <= w_addr_d;
            wdata     <= wdata_d;
            if (!op_wr && phase_end) begin
                if (state == LO) begin
                    rbuf_lo <= SRAM_DQ;
                end
                if (state == HI) begin
                    mem_out <= {SRAM_DQ, rbuf_lo};
                end
            end
        end
    end

    assign SRAM_DQ     = dq_oe ? dq_out : {SRAM_DATA_LEN{1'bz}};
    assign bus.MEM_OUT = mem_out;

    assign dbg_state = state;
    assign dbg_cnt   = cnt;
    assign dbg_dq_oe = dq_oe;
endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a halfword SRAM model on the bus and a word-level
// reference memory that predicts every SRAM cycle, ready and MEM_OUT.
module tb_sram_controller;
  localparam int N = 3;

  logic clk;
  logic rst;
  sram_controller_if bus_if ();
  logic [17:0] sram_addr;
  logic        sram_we_n;
  wire  [15:0] sram_dq;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_cnt;
  logic        dbg_dq_oe;

  sram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_DQ   (sram_dq),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt),
    .dbg_dq_oe (dbg_dq_oe)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: a write commits on the rising strobe; reset drops a pending one
  logic [15:0] sram_mem [0:1023];
  logic        tb_drive;
  logic        pend;
  logic [9:0]  pend_addr;
  logic [15:0] pend_data;

  assign sram_dq = tb_drive ? sram_mem[sram_addr[9:0]] : 16'bz;

  always @(posedge clk) begin
    if (!rst) begin
      pend <= 1'b0;
    end else begin
      if (pend && sram_we_n) begin
        sram_mem[pend_addr] <= pend_data;
        pend <= 1'b0;
      end
      if (!sram_we_n) begin
        pend      <= 1'b1;
        pend_addr <= sram_addr[9:0];
        pend_data <= sram_dq;
      end
    end
  end

  // scoreboard: word-level reference memory and last completed read
  logic [31:0] ref_mem [0:511];
  logic [31:0] last_read;
  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one full word access, checked cycle by cycle from the request cycle
  task automatic run_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input bit gap);
    logic [16:0] w;
    logic [17:0] exp_addr;
    logic [15:0] exp_half;
    int ph;
    int c;
    w = 17'((addr - 32'd1024) >> 2);
    bus_if.MEM_W_EN = wr;
    bus_if.MEM_R_EN = !wr;
    bus_if.ALU_Res  = addr;
    bus_if.Val_Rm   = data;
    tb_drive        = !wr;
    if (gap) begin
      @(negedge clk);
      chk("gap_idle_state", 32'(dbg_state), 32'd0);
    end
    #1;
    chk("accept_ready", 32'(bus_if.ready), 32'd0);
    chk("accept_state", 32'(dbg_state), 32'd0);
    for (int k = 1; k <= 2 * N; k++) begin
      @(negedge clk);
      ph = (k - 1) / N;
      c  = (k - 1) % N;
      exp_addr = {w, ph[0]};
      chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
      chk("sram_we_n", 32'(sram_we_n), (wr && c != N - 1) ? 32'd0 : 32'd1);
      chk("busy_ready", 32'(bus_if.ready), 32'd0);
      if (wr) begin
        exp_half = (ph == 1) ? data[31:16] : data[15:0];
        chk("wr_dq_oe", 32'(dbg_dq_oe), 32'd1);
        chk("wr_dq", 32'(sram_dq), 32'(exp_half));
      end else begin
        chk("rd_dq_oe", 32'(dbg_dq_oe), 32'd0);
      end
    end
    @(negedge clk);
    chk("done_ready", 32'(bus_if.ready), 32'd1);
    chk("done_state", 32'(dbg_state), 32'd3);
    if (wr) ref_mem[w[8:0]] = data;
    else last_read = ref_mem[w[8:0]];
    chk("done_mem_out", bus_if.MEM_OUT, last_read);
  endtask

  task automatic idle_cycles(input int n);
    bus_if.MEM_W_EN = 1'b0;
    bus_if.MEM_R_EN = 1'b0;
    tb_drive        = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus_if.ready), 32'd1);
      chk("idle_we_n", 32'(sram_we_n), 32'd1);
      chk("idle_dq_oe", 32'(dbg_dq_oe), 32'd0);
      chk("idle_state", 32'(dbg_state), 32'd0);
      chk("idle_mem_out", bus_if.MEM_OUT, last_read);
    end
  endtask

  function automatic logic [31:0] word_addr(input int w);
    return 32'd1024 + 32'(w) * 4 + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int wa;
    int wb;
    logic [31:0] old_word;
    logic [31:0] new_word;
    bit b2b;
    checks    = 0;
    failures  = 0;
    last_read = '0;
    pend      = 1'b0;
    pend_addr = '0;
    pend_data = '0;
    for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;

    // reset held with a write request pending
    rst             = 1'b0;
    tb_drive        = 1'b0;
    bus_if.MEM_W_EN = 1'b1;
    bus_if.MEM_R_EN = 1'b0;
    bus_if.ALU_Res  = 32'd1032;
    bus_if.Val_Rm   = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_dq_oe", 32'(dbg_dq_oe), 32'd0);
      chk("rst_mem_out", bus_if.MEM_OUT, 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
    end
    rst = 1'b1;
    run_access(1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);

    idle_cycles(10);
    run_access(1'b0, 32'd1032, 32'h0, 1'b0);
    idle_cycles(1);

    // back-to-back write then read of a different word, enables held
    wa = $urandom_range(0, 511);
    wb = (wa + 1 + $urandom_range(0, 509)) % 512;
    run_access(1'b1, word_addr(wa), $urandom, 1'b0);
    run_access(1'b0, word_addr(wb), 32'h0, 1'b1);

    // random mix of reads/writes, some back-to-back, some with idle gaps
    b2b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wa = (i % 4 == 3) ? wb : $urandom_range(0, 511);
      wb = wa;
      run_access(1'($urandom_range(0, 1)), word_addr(wa), $urandom, b2b);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);

    // abort a write with reset on the second cycle of the high phase
    wa       = $urandom_range(0, 511);
    old_word = ref_mem[wa];
    new_word = $urandom;
    bus_if.MEM_W_EN = 1'b1;
    bus_if.MEM_R_EN = 1'b0;
    bus_if.ALU_Res  = word_addr(wa);
    bus_if.Val_Rm   = new_word;
    #1;
    repeat (5) @(negedge clk);
    chk("abort_pre_state", 32'(dbg_state), 32'd2);
    chk("abort_pre_cnt", 32'(dbg_cnt), 32'd1);
    chk("abort_pre_we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state", 32'(dbg_state), 32'd0);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_dq_oe", 32'(dbg_dq_oe), 32'd0);
    chk("abort_mem_out", bus_if.MEM_OUT, 32'd0);
    rst       = 1'b1;
    last_read = '0;
    ref_mem[wa] = {old_word[31:16], new_word[15:0]};
    idle_cycles(2);
    run_access(1'b0, word_addr(wa), 32'h0, 1'b0);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits downstream of the memory-access stage and replaces the ideal data memory with a real external asynchronous SRAM.
- Converts each 32-bit word read or write from the pipeline into two 16-bit SRAM transactions, low half first, each padded with programmable wait states.
- Drives `ready` low while an access is in flight; the top level ORs `~ready` into the pipeline freeze.

Parameters:
- DATA_LEN, 32, pipeline data width.
- ADDRESS_LEN, 32, pipeline byte-address width.
- SRAM_ADDR_LEN, 18, SRAM halfword-address width.
- SRAM_DATA_LEN, 16, SRAM data width (must equal DATA_LEN/2).
- BASE_ADDR, 1024, byte address mapped to SRAM halfword 0.
- WAIT_CYCLES, 2, extra cycles per halfword phase (phase length N = WAIT_CYCLES+1, N >= 2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-low reset (rst=0 sampled at posedge resets).
- MEM_R_EN  in  1  word read request.
- MEM_W_EN  in  1  word write request.
- ALU_Res  in  ADDRESS_LEN  byte address.
- Val_Rm  in  DATA_LEN  write data.
- MEM_OUT  out  DATA_LEN  read data, registered.
- ready  out  1  access complete / no access pending.
- SRAM_ADDR  out  SRAM_ADDR_LEN  halfword address, registered.
- SRAM_WE_N  out  1  active-low write strobe, registered.
- SRAM_DQ  inout  SRAM_DATA_LEN  bidirectional data bus.

Behaviour:
- States: IDLE, LO, HI, DONE; phase counter cnt in 0..N-1.
- Reset: state=IDLE, cnt=0, SRAM_WE_N=1, SRAM_ADDR=0, MEM_OUT=0, SRAM_DQ released (Z).
- Reset mid-operation aborts the access immediately; a partial write of the low half is permitted and is not rolled back.
- Address mapping: w = (ALU_Res - BASE_ADDR) >> 2, truncated to SRAM_ADDR_LEN-1 bits.
  - LO phase uses SRAM_ADDR = {w, 1'b0}.
  - HI phase uses SRAM_ADDR = {w, 1'b1}.
  - ALU_Res[1:0] is ignored.
- IDLE with MEM_R_EN|MEM_W_EN:
  - Latch op, address and Val_Rm.
  - Go to LO with cnt=0.
  - Write takes priority if both enables are asserted.
  - No request: stay in IDLE.
- LO/HI: each phase lasts exactly N cycles (cnt 0..N-1).
  - On cnt=N-1, LO goes to HI and HI goes to DONE.
  - DONE goes to IDLE unconditionally after 1 cycle.
- Write phase:
  - SRAM_DQ is driven with the latched half (LO: Val_Rm[15:0], HI: Val_Rm[31:16]) for all N cycles.
  - SRAM_WE_N=0 for cnt 0..N-2 and 1 on cnt=N-1, giving data hold time with the address stable.
- Read phase:
  - SRAM_WE_N=1 and SRAM_DQ is Z.
  - SRAM_DQ is sampled on the cnt=N-1 cycle into the low or high half of the read buffer.
- MEM_OUT is updated with the full word on entry to DONE.
  - It holds its value until the next read completes.
  - Writes never change MEM_OUT.
- ready (combinational from state and inputs):
  - 1 in DONE.
  - 1 in IDLE when MEM_R_EN=MEM_W_EN=0.
  - 0 otherwise, including the request-acceptance cycle in IDLE.
- Latency: request seen at cycle 0 gives ready=1 at cycle 2N+1. For WAIT_CYCLES=2 this is cycle 7.
- Requests arriving in LO/HI/DONE are ignored. The pipeline is frozen, so the inputs stay stable.
- A request still asserted in DONE is treated as a new access only after returning to IDLE. This is legal because the pipeline advances on DONE.
- Back-to-back accesses: DONE, then IDLE accepts the next request, giving 1 idle cycle between accesses.
- SRAM_DQ is never driven except in write LO/HI phases; there is no bus contention in IDLE or DONE.

Test Plan:
- Reset hold: rst=0 for 3 cycles with MEM_W_EN=1 -> SRAM_WE_N=1, SRAM_DQ=Z, MEM_OUT=0, state IDLE; after release, the access starts.
- Write: MEM_W_EN=1, ALU_Res=1024+8, Val_Rm=0xDEADBEEF, WAIT_CYCLES=2.
  - Expected SRAM_ADDR=4 with DQ=0xBEEF.
  - SRAM_WE_N low 2 of 3 cycles.
  - Then SRAM_ADDR=5 with DQ=0xDEAD.
  - ready=1 exactly at cycle 7.
- Read back: MEM_R_EN=1, same address, SRAM model returns the stored halves -> MEM_OUT=0xDEADBEEF at DONE, ready=1 at cycle 7, SRAM_WE_N=1 throughout.
- Idle: no enables for 10 cycles -> ready=1 constantly, SRAM_WE_N=1, DQ=Z, MEM_OUT unchanged.
- Back-to-back: a write then a read of different words with the enables held -> two 7-cycle accesses separated by one IDLE cycle; the second access uses new addresses.
- Abort: assert rst=0 at cnt=1 of HI during a write -> next cycle IDLE, SRAM_WE_N=1, DQ=Z; subsequent read of that word returns the new low half and the old high half.
